// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 115200 baud from a ~10 MHz sys_clk
  localparam int CLKS_PER_BIT_115200 = 87;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with sticky overflow; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/stop checking and an output FIFO.
//   state      | meaning
//   WAIT_IDLE  | after reset or break: wait for line high
//   IDLE       | line high, waiting for a start edge
//   START      | start bit; re-checked at mid-bit to reject glitches
//   DATA       | DATA_BITS data bits, LSB first
//   PARITY     | optional parity bit
//   STOP       | STOP_BITS stop bits; push on the last good one
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int INVERT_RX    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Rx_Serial,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Rx_Valid,
  input  logic                          i_Rx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Frame_Err,
  output logic                          o_Parity_Err,
  output logic                          o_Overflow,
  input  logic                          i_Clear_Err,
  output logic                          o_Rx_Active
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int IDX_W = $clog2(DATA_BITS);

  // Timer counts down from CLKS_PER_BIT-1; value = CLKS_PER_BIT-1-elapsed.
  localparam logic [15:0] TMR_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TMR_START  = 16'(CLKS_PER_BIT - 2);
  localparam logic [15:0] TMR_M1     = 16'(CLKS_PER_BIT - MID);
  localparam logic [15:0] TMR_MID    = 16'(CLKS_PER_BIT - 1 - MID);
  localparam logic [15:0] TMR_P1     = 16'(CLKS_PER_BIT - 2 - MID);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             INV       = 1'(INVERT_RX != 0);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 line;
  logic [15:0]          bit_tmr;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sh;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic                 par_exp;
  logic                 par_bad;
  logic                 push_req;
  logic                 frame_err;
  logic                 parity_err;

  assign line    = rx_sync ^ INV;
  assign vote    = majority3(samp_a, samp_b, line);
  assign par_exp = (PARITY == PAR_EVEN) ? ^data_sh : ~^data_sh;

  assign o_Frame_Err  = frame_err;
  assign o_Parity_Err = parity_err;
  assign o_Rx_Active  = (state != ST_IDLE) && (state != ST_WAIT_IDLE);

  // Synchroniser resets to the "line low" level so reception waits for a real idle.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta    <= INV;
      rx_sync    <= INV;
      state      <= ST_WAIT_IDLE;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      data_sh    <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      par_bad    <= 1'b0;
      push_req   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta    <= i_Rx_Serial;
      rx_sync    <= rx_meta;
      push_req   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (o_Rx_Active)         bit_tmr <= bit_tmr - 16'd1;
      if (bit_tmr == TMR_M1)  samp_a  <= line;
      if (bit_tmr == TMR_MID) samp_b  <= line;

      case (state)
        ST_WAIT_IDLE: if (line) state <= ST_IDLE;
        ST_IDLE: begin
          if (!line) begin
            state   <= ST_START;
            bit_tmr <= TMR_START;
            par_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_tmr == TMR_MID && line) begin
            state <= ST_IDLE;
          end else if (bit_tmr == '0) begin
            state   <= ST_DATA;
            bit_tmr <= TMR_RELOAD;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_tmr == TMR_P1) data_sh[bit_idx] <= vote;
          if (bit_tmr == '0) begin
            bit_tmr <= TMR_RELOAD;
            if (bit_idx == IDX_LAST) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tmr == TMR_P1 && vote != par_exp) begin
            parity_err <= 1'b1;
            par_bad    <= 1'b1;
          end
          if (bit_tmr == '0) begin
            state    <= ST_STOP;
            bit_tmr  <= TMR_RELOAD;
            stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (bit_tmr == TMR_P1) begin
            if (!vote) begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end else if (stop_idx == STOP_LAST) begin
              state    <= ST_IDLE;
              push_req <= !par_bad;
            end
          end else if (bit_tmr == '0) begin
            bit_tmr  <= TMR_RELOAD;
            stop_idx <= 1'b1;
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk  (i_Clock),
    .rst_n    (i_Rst_n),
    .push     (push_req),
    .wdata    (data_sh),
    .pop      (i_Rx_Ready),
    .clr_ovf  (i_Clear_Err),
    .rdata    (o_Rx_Data),
    .valid    (o_Rx_Valid),
    .count    (o_Fifo_Count),
    .overflow (o_Overflow)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: default 8N1 inverted instance plus an even-parity, 2-stop instance.
module tb_uart_rx_fifo;

  localparam int CPB_A = 87;
  localparam int CPB_B = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, ready_a, clr_a;
  logic [7:0] data_a;
  logic       valid_a, ferr_a, perr_a, ovf_a, active_a;
  logic [4:0] count_a;
  logic       rx_b, ready_b, clr_b;
  logic [7:0] data_b;
  logic       valid_b, ferr_b, perr_b, ovf_b, active_b;
  logic [4:0] count_b;

  int errors = 0;
  int checks = 0;
  int ferr_a_n = 0, perr_a_n = 0, ferr_b_n = 0, perr_b_n = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx_fifo dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .o_Rx_Data(data_a),
    .o_Rx_Valid(valid_a), .i_Rx_Ready(ready_a), .o_Fifo_Count(count_a),
    .o_Frame_Err(ferr_a), .o_Parity_Err(perr_a), .o_Overflow(ovf_a),
    .i_Clear_Err(clr_a), .o_Rx_Active(active_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
    .INVERT_RX(0), .FIFO_DEPTH(16)
  ) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .o_Rx_Data(data_b),
    .o_Rx_Valid(valid_b), .i_Rx_Ready(ready_b), .o_Fifo_Count(count_b),
    .o_Frame_Err(ferr_b), .o_Parity_Err(perr_b), .o_Overflow(ovf_b),
    .i_Clear_Err(clr_b), .o_Rx_Active(active_b)
  );

  always @(negedge clk) begin
    if (ferr_a === 1'b1) ferr_a_n++;
    if (perr_a === 1'b1) perr_a_n++;
    if (ferr_b === 1'b1) ferr_b_n++;
    if (perr_b === 1'b1) perr_b_n++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Logical level v on the selected line; instance A sits behind an inverting transceiver.
  task automatic drive_line(input bit sel, input bit v, input int n);
    if (sel) rx_b = v;
    else     rx_a = ~v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int cpb, input bit use_par,
                            input bit par_bit, input bit stop1, input bit stop2, input bit two_stop);
    drive_line(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_line(sel, d[i], cpb);
    if (use_par)  drive_line(sel, par_bit, cpb);
    drive_line(sel, stop1, cpb);
    if (two_stop) drive_line(sel, stop2, cpb);
  endtask

  task automatic drain_a();
    bit         done;
    logic [7:0] e;
    done    = 1'b0;
    ready_a = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (valid_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %0h, expected no data", data_a);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {24'd0, data_a}, {24'd0, e});
        end
      end else if (exp_q.size() == 0) begin
        done = 1'b1;
      end
    end
    tick();
    ready_a = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("drain_count", 32'(count_a), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, p0;
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 1'b1};
    vecs[4] = '{8'h81, 1'b0};
    vecs[5] = '{8'h3C, 1'b1};

    rst_n = 1'b0; rx_a = 1'b0; rx_b = 1'b1;
    ready_a = 1'b0; clr_a = 1'b0; ready_b = 1'b0; clr_b = 1'b0;
    repeat (3) tick();
    chk("rst_valid",  32'(valid_a),  0);
    chk("rst_count",  32'(count_a),  0);
    chk("rst_data",   32'(data_a),   0);
    chk("rst_ovf",    32'(ovf_a),    0);
    chk("rst_active", 32'(active_a), 0);
    chk("rst_errs",   32'({ferr_a, perr_a}), 0);
    rst_n = 1'b1;
    drive_line(0, 1'b1, 20);
    chk("idle_active", 32'(active_a), 0);

    // Single 0xA5 with a timing window around the push
    exp_q.push_back(8'hA5);
    fork
      send_frame(0, 8'hA5, CPB_A, 0, 0, 1, 1, 0);
      begin
        repeat (822) tick();
        chk("a5_valid_early", 32'(valid_a), 0);
        repeat (23) tick();
        chk("a5_valid_late", 32'(valid_a), 1);
        chk("a5_data",       32'(data_a),  32'hA5);
        chk("a5_count",      32'(count_a), 1);
      end
    join
    drive_line(0, 1'b1, 20);
    chk("a5_no_ferr", 32'(ferr_a_n), 0);
    drain_a();

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_a_n;
      if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
      send_frame(0, vecs[i].data, CPB_A, 0, 0, vecs[i].stop_ok, 1, 0);
      drive_line(0, 1'b1, 40);
      chk($sformatf("vec%0d_ferr", i),   32'(ferr_a_n - f0), 32'(!vecs[i].stop_ok));
      chk($sformatf("vec%0d_count", i),  32'(count_a),       32'(vecs[i].stop_ok));
      chk($sformatf("vec%0d_active", i), 32'(active_a),      0);
      drain_a();
    end

    // Glitch: 20 low cycles is shorter than half a bit
    f0 = ferr_a_n;
    drive_line(0, 1'b0, 10);
    chk("glitch_active_start", 32'(active_a), 1);
    drive_line(0, 1'b0, 10);
    drive_line(0, 1'b1, CPB_A);
    chk("glitch_active_end", 32'(active_a), 0);
    chk("glitch_count", 32'(count_a), 0);
    chk("glitch_ferr",  32'(ferr_a_n - f0), 0);

    // Break: stop bit low and line held low
    f0 = ferr_a_n;
    send_frame(0, 8'h00, CPB_A, 0, 0, 0, 1, 0);
    drive_line(0, 1'b0, 3 * CPB_A);
    chk("break_ferr",   32'(ferr_a_n - f0), 1);
    chk("break_active", 32'(active_a), 0);
    chk("break_count",  32'(count_a), 0);
    drive_line(0, 1'b1, CPB_A);
    exp_q.push_back(8'h66);
    send_frame(0, 8'h66, CPB_A, 0, 0, 1, 1, 0);
    drive_line(0, 1'b1, 40);
    drain_a();

    // Overflow: 17 bytes into a 16-deep FIFO, nobody reading
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) exp_q.push_back(8'(k));
      send_frame(0, 8'(k), CPB_A, 0, 0, 1, 1, 0);
    end
    drive_line(0, 1'b1, 40);
    chk("ovf_count", 32'(count_a), 16);
    chk("ovf_flag",  32'(ovf_a),   1);
    chk("ovf_head",  32'(data_a),  1);
    chk("ovf_valid", 32'(valid_a), 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    chk("ovf_cleared", 32'(ovf_a),   0);
    chk("ovf_count2",  32'(count_a), 16);
    drain_a();

    // Reset in the middle of data bit 3, released with the line still low
    f0 = ferr_a_n;
    drive_line(0, 1'b0, 4 * CPB_A + 43);
    rst_n = 1'b0;
    drive_line(0, 1'b0, 5);
    chk("midrst_active", 32'(active_a), 0);
    rst_n = 1'b1;
    drive_line(0, 1'b0, 2 * CPB_A);
    chk("midrst_wait_active", 32'(active_a), 0);
    chk("midrst_count", 32'(count_a), 0);
    chk("midrst_ferr",  32'(ferr_a_n - f0), 0);
    drive_line(0, 1'b1, CPB_A);
    exp_q.push_back(8'h3C);
    send_frame(0, 8'h3C, CPB_A, 0, 0, 1, 1, 0);
    drive_line(0, 1'b1, 40);
    chk("midrst_next_count", 32'(count_a), 1);
    drain_a();

    // Instance B: even parity, two stop bits, non-inverted line
    p0 = perr_b_n;
    send_frame(1, 8'h07, CPB_B, 1, 0, 1, 1, 1);
    drive_line(1, 1'b1, 40);
    chk("par_bad_perr",  32'(perr_b_n - p0), 1);
    chk("par_bad_count", 32'(count_b), 0);
    send_frame(1, 8'h07, CPB_B, 1, 1, 1, 1, 1);
    drive_line(1, 1'b1, 40);
    chk("par_ok_perr",  32'(perr_b_n - p0), 1);
    chk("par_ok_count", 32'(count_b), 1);
    chk("par_ok_data",  32'(data_b),  32'h07);
    f0 = ferr_b_n;
    send_frame(1, 8'h80, CPB_B, 1, 1, 1, 0, 1);
    drive_line(1, 1'b1, 40);
    chk("stop2_ferr",  32'(ferr_b_n - f0), 1);
    chk("stop2_count", 32'(count_b), 1);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    tick();
    chk("b_pop_count", 32'(count_b), 0);
    chk("b_pop_valid", 32'(valid_b), 0);

    chk("a_no_perr", 32'(perr_a_n), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: sys_clk cycles per bit (legal 16..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame (legal 5..9).
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked (1 or 2).
REQ-005 SHALL have parameter INVERT_RX, default 1: 1 inverts the line, for the RS232-polarity transceiver.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: entries, power of two, 2..256.
REQ-007 SHALL have port i_Clock  in  1  sys_clk; the only clock.
REQ-008 SHALL have port i_Rst_n  in  1  reset: synchronous, active-low.
REQ-009 SHALL have port i_Rx_Serial  in  1  asynchronous serial line from the pin.
REQ-010 SHALL have port o_Rx_Data  out  DATA_BITS  FIFO head byte.
REQ-011 SHALL have port o_Rx_Valid  out  1  FIFO not empty.
REQ-012 SHALL have port i_Rx_Ready  in  1  consumer accepts the head byte.
REQ-013 SHALL have port o_Fifo_Count  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 SHALL have port o_Frame_Err  out  1  one-cycle pulse on a bad stop bit.
REQ-015 SHALL have port o_Parity_Err  out  1  one-cycle pulse on a parity mismatch.
REQ-016 SHALL have port o_Overflow  out  1  sticky; a byte was dropped because the FIFO was full.
REQ-017 SHALL have port i_Clear_Err  in  1  clears o_Overflow.
REQ-018 SHALL have port o_Rx_Active  out  1  high in every state except IDLE and WAIT_IDLE.

Function
REQ-019 SHALL pass i_Rx_Serial through a 2-FF synchroniser, then invert it when INVERT_RX=1; "line" below means this signal.
REQ-020 SHALL implement the states WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
- WAIT_IDLE goes to IDLE once line is high.
- IDLE goes to START when line is low.
REQ-021 START SHALL sample line at CLKS_PER_BIT/2; line high there (glitch) returns the FSM to IDLE with no error and no push.
REQ-022 Each data, parity and stop bit SHALL be taken as the majority vote of line at mid-1, mid and mid+1 of the bit, with mid = CLKS_PER_BIT/2 from the bit start.
REQ-023 Data SHALL be assembled LSB first into DATA_BITS bits; the bit counter SHALL wrap at DATA_BITS-1.
REQ-024 When PARITY=0 the PARITY state SHALL be skipped.
REQ-025 A parity mismatch SHALL pulse o_Parity_Err and discard the byte.
REQ-026 Each of STOP_BITS stop bits SHALL be checked; any stop bit low SHALL pulse o_Frame_Err, discard the byte, and enter WAIT_IDLE (break handling).
REQ-027 After the last stop-bit vote with no error, the FSM SHALL return to IDLE in the next cycle, so back-to-back frames are accepted.
REQ-028 A good byte SHALL be pushed into the FIFO in the cycle after the last stop-bit vote.
REQ-029 When the FIFO was empty, o_Rx_Valid SHALL assert in the cycle after the push (first-word-fall-through).
REQ-030 A pop SHALL occur when o_Rx_Valid and i_Rx_Ready are both high.
REQ-031 o_Rx_Data SHALL stay stable while o_Rx_Valid=1 and i_Rx_Ready=0.
REQ-032 A push while the FIFO is full with no pop in the same cycle SHALL drop the byte and set o_Overflow; the FIFO contents are unchanged.
REQ-033 A push and a pop in the same cycle with the FIFO full SHALL both be performed; the count stays FIFO_DEPTH and no overflow is flagged.
REQ-034 A push and a pop in the same cycle with the FIFO empty SHALL perform only the push; a pop on empty is ignored.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 o_Fifo_Count SHALL range 0..FIFO_DEPTH, updated in the cycle after each push/pop.
REQ-037 i_Clear_Err and a new overflow in the same cycle SHALL leave o_Overflow set (set wins).

Reset
REQ-038 While i_Rst_n=0 at a clock edge: the FSM SHALL go to WAIT_IDLE and the FIFO SHALL empty.
REQ-039 While i_Rst_n=0 at a clock edge: o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Overflow and o_Rx_Active SHALL all be 0.
REQ-040 While i_Rst_n=0 at a clock edge: o_Fifo_Count SHALL be 0 and o_Rx_Data SHALL be all zeros.
REQ-041 A reset asserted mid-frame SHALL abandon the frame with no push and no error pulse.
REQ-042 After reset release, reception SHALL start only once line has been seen high.

Structure
REQ-043 Package uart_pkg SHALL hold the FSM state enum, the parity-mode constants (PAR_NONE/ODD/EVEN), and the default CLKS_PER_BIT for 115200 baud.
REQ-044 The FIFO SHALL be the sub-module sync_fifo, parametrised by WIDTH and DEPTH; the same reset and clock as this block are used throughout.

Verification
REQ-045 Defaults; send 0xA5 at 87 clk/bit, 8N1, inverted line -> one push; o_Rx_Data=0xA5 and o_Rx_Valid=1 two cycles after the stop-bit mid vote; no error pulses.
REQ-046 PARITY=2; send 0x07 with parity bit 0 (wrong) -> o_Parity_Err pulses once; o_Fifo_Count stays 0.
REQ-047 Line low for 20 cycles, then high -> back to IDLE; no push, no errors.
REQ-048 Send 0x00 with stop bit low (break) -> o_Frame_Err pulses; FSM waits in WAIT_IDLE until line is high.
REQ-049 i_Rx_Ready=0; send 17 bytes 0x01..0x11 -> count=16, o_Overflow=1, head=0x01; drain -> sequence 0x01..0x10.
REQ-050 Reset at data bit 3 of a frame; release with line low -> no push; the next valid frame 0x3C is received correctly.
